// File: rtl/instr_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instr_boot_loader
// Purpose  : Program-load stage for the instruction memory. Receives a byte
//            stream made of a 16-bit little-endian word-count header followed
//            by little-endian 32-bit instruction words. Each assembled word is
//            written to consecutive word addresses from 0 with a
//            request/valid handshake. core_enable is raised once the whole
//            program has been written.
// Ports    : clk, rst (async, active-high)
//            start                  - begin a load (IDLE/DONE/ERR only)
//            rx_data/rx_valid/rx_ready - byte stream handshake
//            mem_request/mem_we_re/mem_mask/mem_address/mem_w_data/mem_valid
//                                   - instruction-memory write port
//            core_enable            - program loaded, core may run
//            load_error             - header count larger than memory depth
//            words_loaded           - words written since last start
// Revision : 1.0 - initial release
// ============================================================================
module instr_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_w_data,
    input  logic              mem_valid,
    output logic              core_enable,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LEN0  = 3'd1;
    localparam logic [2:0] c_S_LEN1  = 3'd2;
    localparam logic [2:0] c_S_BYTE  = 3'd3;
    localparam logic [2:0] c_S_WRITE = 3'd4;
    localparam logic [2:0] c_S_DONE  = 3'd5;
    localparam logic [2:0] c_S_ERR   = 3'd6;

    // Memory depth, one bit wider than the 16-bit header so 2**16 is representable.
    localparam logic [16:0] c_DEPTH = 17'(1) << ADDR_W;

    logic [2:0]        r_state;
    logic [15:0]       r_len;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_data;
    logic              r_core_enable;
    logic              r_load_error;

    logic              w_rx_ready;
    logic              w_accept;
    logic [15:0]       w_len_full;
    logic [ADDR_W:0]   w_count_next;
    logic              w_last_word;

    // rx_ready is a pure decode of the state so the stream stalls while a
    // write is outstanding and in every non-receiving state.
    assign w_rx_ready   = (r_state == c_S_LEN0) || (r_state == c_S_LEN1) ||
                          (r_state == c_S_BYTE);
    assign w_accept     = rx_valid && w_rx_ready;
    assign w_len_full   = {rx_data, r_len[7:0]};
    assign w_count_next = r_count + 1'b1;
    assign w_last_word  = (17'(w_count_next) == {1'b0, r_len});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_S_IDLE;
            r_len         <= '0;
            r_byte_idx    <= '0;
            r_addr        <= '0;
            r_count       <= '0;
            r_data        <= '0;
            r_core_enable <= 1'b0;
            r_load_error  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE, c_S_DONE, c_S_ERR: begin
                    if (start) begin
                        r_state       <= c_S_LEN0;
                        r_addr        <= '0;
                        r_count       <= '0;
                        r_byte_idx    <= '0;
                        r_core_enable <= 1'b0;
                        r_load_error  <= 1'b0;
                    end
                end
                c_S_LEN0: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_state    <= c_S_LEN1;
                    end
                end
                c_S_LEN1: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        if (w_len_full == 16'd0) begin
                            r_state       <= c_S_DONE;
                            r_core_enable <= 1'b1;
                        end else if ({1'b0, w_len_full} > c_DEPTH) begin
                            r_state      <= c_S_ERR;
                            r_load_error <= 1'b1;
                        end else begin
                            r_state <= c_S_BYTE;
                        end
                    end
                end
                c_S_BYTE: begin
                    if (w_accept) begin
                        r_data[8*r_byte_idx +: 8] <= rx_data;
                        r_byte_idx                <= r_byte_idx + 1'b1;
                        if (r_byte_idx == 2'd3) begin
                            r_state <= c_S_WRITE;
                        end
                    end
                end
                c_S_WRITE: begin
                    if (mem_valid) begin
                        // Address wraps naturally; it only reaches the top
                        // when the header asked for the full memory depth.
                        r_addr  <= r_addr + 1'b1;
                        r_count <= w_count_next;
                        if (w_last_word) begin
                            r_state       <= c_S_DONE;
                            r_core_enable <= 1'b1;
                        end else begin
                            r_state <= c_S_BYTE;
                        end
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready     = w_rx_ready;
    assign mem_request  = (r_state == c_S_WRITE);
    assign mem_we_re    = mem_request;
    assign mem_mask     = mem_request ? 4'b1111 : 4'b0000;
    assign mem_address  = r_addr;
    assign mem_w_data   = r_data;
    assign core_enable  = r_core_enable;
    assign load_error   = r_load_error;
    assign words_loaded = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_boot_loader
// Purpose  : Self-checking bench for instr_boot_loader. A table of load
//            scenarios is replayed in a loop; hand-written sequences cover a
//            full-depth load with a stalling stream and a mid-write reset.
//            A memory responder answers requests after a programmable delay
//            and records every write for later comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_boot_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              start     = 1'b0;
    logic [7:0]        rx_data   = 8'h00;
    logic              rx_valid  = 1'b0;
    logic              mem_valid = 1'b0;
    logic              rx_ready;
    logic              mem_request;
    logic              mem_we_re;
    logic [3:0]        mem_mask;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_w_data;
    logic              core_enable;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    instr_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_request  (mem_request),
        .mem_we_re    (mem_we_re),
        .mem_mask     (mem_mask),
        .mem_address  (mem_address),
        .mem_w_data   (mem_w_data),
        .mem_valid    (mem_valid),
        .core_enable  (core_enable),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory responder / write recorder
    // ------------------------------------------------------------------
    int          resp_delay = 0;
    int          resp_wait  = 0;
    logic [31:0] mem_m [0:DEPTH-1];
    int          wcnt  [0:DEPTH-1];
    int          total_writes = 0;
    logic        prev_req  = 1'b0;
    logic [7:0]  prev_addr = 8'h00;
    logic [31:0] prev_data = 32'h0;

    always @(negedge clk) begin
        if (mem_request) begin
            check("req_rx_ready", 32'(rx_ready), 32'd0);
            check("req_mask", 32'(mem_mask), 32'hF);
            check("req_we_re", 32'(mem_we_re), 32'd1);
            if (prev_req) begin
                check("hold_addr", 32'(mem_address), 32'(prev_addr));
                check("hold_data", mem_w_data, prev_data);
            end
            if (resp_wait >= resp_delay) begin
                mem_valid = 1'b1;
                mem_m[mem_address] = mem_w_data;
                wcnt[mem_address]++;
                total_writes++;
            end else begin
                mem_valid = 1'b0;
                resp_wait++;
            end
        end else begin
            check("idle_mask", 32'(mem_mask), 32'd0);
            mem_valid = 1'b0;
            resp_wait = 0;
        end
        prev_req  = mem_request && !mem_valid;
        prev_addr = mem_address;
        prev_data = mem_w_data;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic clear_model(input int delay);
        for (int i = 0; i < DEPTH; i++) wcnt[i] = 0;
        total_writes = 0;
        resp_delay   = delay;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_core_enable(output int cycles);
        cycles = 0;
        while (!core_enable && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 60) check("core_enable_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_rx_ready"},    32'(rx_ready),     32'd0);
        check({pfx, "_mem_request"}, 32'(mem_request),  32'd0);
        check({pfx, "_mem_we_re"},   32'(mem_we_re),    32'd0);
        check({pfx, "_mem_mask"},    32'(mem_mask),     32'd0);
        check({pfx, "_mem_address"}, 32'(mem_address),  32'd0);
        check({pfx, "_mem_w_data"},  mem_w_data,        32'd0);
        check({pfx, "_core_enable"}, 32'(core_enable),  32'd0);
        check({pfx, "_load_error"},  32'(load_error),   32'd0);
        check({pfx, "_words"},       32'(words_loaded), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Table of small load scenarios
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          delay;
        logic        exp_done;
        logic        exp_err;
        int          exp_words;
    } vec_t;

    vec_t vecs [0:4];

    task automatic run_load(input vec_t v);
        int          cycles;
        logic [31:0] word;
        clear_model(v.delay);
        pulse_start();
        check("start_rx_ready", 32'(rx_ready),     32'd1);
        check("start_core_en",  32'(core_enable),  32'd0);
        check("start_err",      32'(load_error),   32'd0);
        check("start_words",    32'(words_loaded), 32'd0);
        send_byte(v.len[7:0], 0);
        send_byte(v.len[15:8], 0);
        if (v.exp_err) begin
            check("err_rx_ready", 32'(rx_ready), 32'd0);
        end else if (v.len == 16'd0) begin
            check("zero_len_core_en", 32'(core_enable), 32'd1);
        end else begin
            for (int w = 0; w < int'(v.len); w++) begin
                word = (w == 0) ? v.w0 : v.w1;
                for (int k = 0; k < 4; k++) send_byte(word[8*k +: 8], 0);
            end
            wait_core_enable(cycles);
            check("done_latency", 32'(cycles), 32'(v.delay + 2));
        end
        check("end_core_en",  32'(core_enable),  32'(v.exp_done));
        check("end_err",      32'(load_error),   32'(v.exp_err));
        check("end_words",    32'(words_loaded), 32'(v.exp_words));
        check("end_writes",   32'(total_writes), 32'(v.exp_words));
        for (int w = 0; w < v.exp_words; w++) begin
            check("mem_data",  mem_m[w], (w == 0) ? v.w0 : v.w1);
            check("mem_count", 32'(wcnt[w]), 32'd1);
        end
    endtask

    function automatic logic [31:0] pattern(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, 8'h5A, b ^ 8'h3C};
    endfunction

    // Full-depth load with a randomly stalling stream and an ignored
    // mid-load start.
    task automatic load_full();
        int          cycles;
        logic [31:0] word;
        int          n;
        clear_model(0);
        pulse_start();
        send_byte(8'h00, 1);
        send_byte(8'h01, 2);
        check("full_not_err", 32'(load_error), 32'd0);
        for (int w = 0; w < DEPTH; w++) begin
            word = pattern(w);
            for (int k = 0; k < 4; k++) send_byte(word[8*k +: 8], int'($urandom_range(0, 2)));
            if (w == 9) begin
                n = 0;
                while (mem_request && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                pulse_start();
                check("ignored_start_words",    32'(words_loaded), 32'd10);
                check("ignored_start_rx_ready", 32'(rx_ready),     32'd1);
                check("ignored_start_core_en",  32'(core_enable),  32'd0);
            end
        end
        wait_core_enable(cycles);
        check("full_core_en", 32'(core_enable),  32'd1);
        check("full_words",   32'(words_loaded), 32'd256);
        check("full_writes",  32'(total_writes), 32'd256);
        for (int a = 0; a < DEPTH; a++) begin
            check("full_mem_data",  mem_m[a], pattern(a));
            check("full_mem_count", 32'(wcnt[a]), 32'd1);
        end
    endtask

    // Reset asserted while the second word is waiting on the memory.
    task automatic reset_mid_write();
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = 32'h11223344;
        w1 = 32'hCAFEF00D;
        clear_model(6);
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0);
        for (int k = 0; k < 4; k++) send_byte(w1[8*k +: 8], 0);
        repeat (2) @(negedge clk);
        check("pre_rst_request", 32'(mem_request),  32'd1);
        check("pre_rst_address", 32'(mem_address), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        check("rst_partial_mem", mem_m[0], w0);
        check("rst_partial_cnt", 32'(total_writes), 32'd1);
    endtask

    initial begin
        vecs[0] = '{len: 16'd2,     w0: 32'h00100513, w1: 32'h00100073, delay: 0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_words: 2};
        vecs[1] = '{len: 16'd2,     w0: 32'h00100513, w1: 32'h00100073, delay: 3,
                    exp_done: 1'b1, exp_err: 1'b0, exp_words: 2};
        vecs[2] = '{len: 16'd0,     w0: 32'h0,        w1: 32'h0,        delay: 0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_words: 0};
        vecs[3] = '{len: 16'h0101,  w0: 32'h0,        w1: 32'h0,        delay: 0,
                    exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
        vecs[4] = '{len: 16'd1,     w0: 32'hDEADBEEF, w1: 32'h0,        delay: 1,
                    exp_done: 1'b1, exp_err: 1'b0, exp_words: 1};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_no_start");

        for (int i = 0; i < 5; i++) run_load(vecs[i]);

        load_full();
        reset_mid_write();
        run_load(vecs[0]);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
